qed_imem_loader: RTL and testbench

- Parametrised successor to the single-word QED memory shim.
- Takes the QED instruction stream (valid + instruction) and buffers it in a small FIFO.
- Drains the FIFO into the instruction-memory write port at sequential word addresses from BASE_ADDR, gated by a port-ready handshake.
- Supports wrap-around or halt-on-full fill modes, back-pressure to QED, a sticky overflow flag, and a restart.
- Sits between the qed module and the i_mem write port (port A) in design_top.

---
 rtl/qed_imem_loader.sv | 143 ++++++++++++++
 tb/tb_qed_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_imem_loader.sv
// QED instruction-stream loader: buffers QED instructions in a small FIFO and
// drains them into the instruction-memory write port at sequential word addresses.
module qed_imem_loader #(
    parameter int unsigned         DATA_W     = 32,
    parameter int unsigned         ADDR_W     = 32,
    parameter int unsigned         DEPTH      = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR  = '0,
    parameter int unsigned         FIFO_DEPTH = 4,
    parameter int unsigned         WRAP_MODE  = 1,
    parameter int unsigned         CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              qed_vld_i,
    input  logic [DATA_W-1:0] qed_instr_i,
    output logic              qed_stall_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_w_en_o,
    input  logic              restart_i,
    output logic              full_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned WPTR_W = $clog2(DEPTH);
    localparam int unsigned FPTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = FPTR_W + 1;
    localparam logic [WPTR_W-1:0] WPTR_LAST = WPTR_W'(DEPTH - 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(FIFO_DEPTH);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    typedef enum logic [1:0] {StIdle, StDrain, StHalt} state_e;

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    fifo_q [FIFO_DEPTH];
    logic [FPTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [FCNT_W-1:0]    fcnt_q;
    logic [WPTR_W-1:0]    wptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q, full_q;
    logic                 mem_w_en_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_data_q;

    logic fifo_empty, fifo_full, pop, push, stall, last_word;

    // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
    // only stalls QED when the memory side is not draining.
    always_comb begin
        fifo_empty = (fcnt_q == '0);
        fifo_full  = (fcnt_q == FCNT_FULL);
        pop        = !fifo_empty && mem_ready_i && (state_q != StHalt);
        stall      = fifo_full && !pop;
        push       = qed_vld_i && !stall;
        last_word  = pop && (WRAP_MODE == 0) && (wptr_q == WPTR_LAST);
    end

    // Next-state logic for the drain controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (push) state_d = StDrain;
            StDrain: begin
                if (last_word) begin
                    state_d = StHalt;
                end else if (pop && !push && (fcnt_q == FCNT_ONE)) begin
                    state_d = StIdle;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State register; restart behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by fcnt_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= qed_instr_i;
        end
    end

    // FIFO pointers, write pointer, counters, flags and registered write port.
    always_ff @(posedge clk_i) begin
        if (rst_i || restart_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fcnt_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            mem_w_en_q <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_data_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FPTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + FCNT_W'(1);
                2'b01:   fcnt_q <= fcnt_q - FCNT_W'(1);
                default: fcnt_q <= fcnt_q;
            endcase
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + FPTR_W'(1);
                mem_w_en_q <= 1'b1;
                mem_data_q <= fifo_q[rd_ptr_q];
                mem_addr_q <= BASE_ADDR + ADDR_W'({wptr_q, 2'b00});
                // Natural power-of-two rollover gives the wrap-mode behaviour.
                wptr_q     <= wptr_q + WPTR_W'(1);
                count_q    <= count_q + CNT_W'(1);
            end else begin
                mem_w_en_q <= 1'b0;
            end
            if (last_word) begin
                full_q <= 1'b1;
            end
            if (qed_vld_i && stall) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign qed_stall_o = stall;
    assign mem_w_en_o  = mem_w_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;
    assign full_o      = full_q;
    assign overflow_o  = overflow_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_qed_imem_loader.sv
// Self-checking bench for qed_imem_loader: three instances (default, wrap with
// DEPTH=4/BASE=0x100, halt with DEPTH=4) share stimulus; writes go to scoreboards.
module tb_qed_imem_loader;

    logic        clk;
    logic        rst, restart, vld, rdy;
    logic [31:0] instr;

    logic        m_stall, m_wen, m_full, m_ovf;
    logic [31:0] m_addr, m_data;
    logic [15:0] m_cnt;
    logic        w_stall, w_wen, w_full, w_ovf;
    logic [31:0] w_addr, w_data;
    logic [15:0] w_cnt;
    logic        h_stall, h_wen, h_full, h_ovf;
    logic [31:0] h_addr, h_data;
    logic [15:0] h_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q_main[$];
    wr_t q_wrap[$];
    wr_t q_halt[$];
    bit  mon_main = 1'b1;
    bit  mon_wrap = 1'b0;
    bit  mon_halt = 1'b0;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [31:0] instr;
        bit          rdy;
        bit          chk_stall;
        bit          stall;
        bit          wr;
        logic [31:0] waddr;
        logic [15:0] cnt;
        bit          ovf;
    } row_t;

    row_t rows[$];

    qed_imem_loader u_main (
        .clk_i(clk), .rst_i(rst), .qed_vld_i(vld), .qed_instr_i(instr),
        .qed_stall_o(m_stall), .mem_ready_i(rdy), .mem_addr_o(m_addr),
        .mem_data_o(m_data), .mem_w_en_o(m_wen), .restart_i(restart),
        .full_o(m_full), .overflow_o(m_ovf), .count_o(m_cnt)
    );

    qed_imem_loader #(.DEPTH(4), .BASE_ADDR(32'h100), .WRAP_MODE(1)) u_wrap (
        .clk_i(clk), .rst_i(rst), .qed_vld_i(vld), .qed_instr_i(instr),
        .qed_stall_o(w_stall), .mem_ready_i(rdy), .mem_addr_o(w_addr),
        .mem_data_o(w_data), .mem_w_en_o(w_wen), .restart_i(restart),
        .full_o(w_full), .overflow_o(w_ovf), .count_o(w_cnt)
    );

    qed_imem_loader #(.DEPTH(4), .WRAP_MODE(0)) u_halt (
        .clk_i(clk), .rst_i(rst), .qed_vld_i(vld), .qed_instr_i(instr),
        .qed_stall_o(h_stall), .mem_ready_i(rdy), .mem_addr_o(h_addr),
        .mem_data_o(h_data), .mem_w_en_o(h_wen), .restart_i(restart),
        .full_o(h_full), .overflow_o(h_ovf), .count_o(h_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_cmp(input string nm, input bit have, input wr_t e,
                          input logic [31:0] a, input logic [31:0] d);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s_write: got write addr=%h data=%h expected no write", nm, a, d);
        end else if (a !== e.addr || d !== e.data) begin
            errors++;
            $display("FAIL %s_write: got addr=%h data=%h expected addr=%h data=%h",
                     nm, a, d, e.addr, e.data);
        end
    endtask

    // Write monitors: every strobe must match the next expected write in order.
    always @(negedge clk) begin
        wr_t e;
        bit  have;
        e = '{addr: '0, data: '0};
        if (mon_main && m_wen === 1'b1) begin
            have = (q_main.size() != 0);
            if (have) e = q_main.pop_front();
            sb_cmp("main", have, e, m_addr, m_data);
        end
        if (mon_wrap && w_wen === 1'b1) begin
            have = (q_wrap.size() != 0);
            if (have) e = q_wrap.pop_front();
            sb_cmp("wrap", have, e, w_addr, w_data);
        end
        if (mon_halt && h_wen === 1'b1) begin
            have = (q_halt.size() != 0);
            if (have) e = q_halt.pop_front();
            sb_cmp("halt", have, e, h_addr, h_data);
        end
    end

    task automatic drive(input bit r, input bit rs, input bit v, input logic [31:0] ins,
                         input bit rd);
        rst     = r;
        restart = rs;
        vld     = v;
        instr   = ins;
        rdy     = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit r, input bit v, input logic [31:0] ins, input bit rd,
                       input bit cs, input bit st, input bit wr, input logic [31:0] wa,
                       input logic [15:0] cnt, input bit ovf);
        row_t x;
        x = '{rst: r, vld: v, instr: ins, rdy: rd, chk_stall: cs, stall: st,
              wr: wr, waddr: wa, cnt: cnt, ovf: ovf};
        rows.push_back(x);
    endtask

    initial begin
        drive(1, 0, 0, 0, 1);

        // Basic in-order drain, then buffering with memory not ready and overflow.
        add(1, 0, 32'h0,        1, 0, 0, 0, 32'h0,  16'd0, 0);
        add(0, 1, 32'h00000013, 1, 1, 0, 1, 32'h0,  16'd0, 0);
        add(0, 1, 32'h00100093, 1, 1, 0, 1, 32'h4,  16'd1, 0);
        add(0, 1, 32'h00200113, 1, 1, 0, 1, 32'h8,  16'd2, 0);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  16'd3, 0);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  16'd3, 0);
        add(0, 1, 32'hA0000000, 0, 1, 0, 1, 32'hC,  16'd3, 0);
        add(0, 1, 32'hA0000001, 0, 1, 0, 1, 32'h10, 16'd3, 0);
        add(0, 1, 32'hA0000002, 0, 1, 0, 1, 32'h14, 16'd3, 0);
        add(0, 1, 32'hA0000003, 0, 1, 0, 1, 32'h18, 16'd3, 0);
        add(0, 1, 32'hA0000004, 0, 1, 1, 0, 32'h0,  16'd3, 1);
        add(0, 0, 32'h0,        0, 1, 1, 0, 32'h0,  16'd3, 1);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  16'd4, 1);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  16'd5, 1);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  16'd6, 1);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  16'd7, 1);
        add(0, 0, 32'h0,        1, 1, 0, 0, 32'h0,  16'd7, 1);

        foreach (rows[i]) begin
            drive(rows[i].rst, 0, rows[i].vld, rows[i].instr, rows[i].rdy);
            if (rows[i].wr) q_main.push_back('{addr: rows[i].waddr, data: rows[i].instr});
            #1;
            if (rows[i].chk_stall) chk($sformatf("row%0d_stall", i), 32'(m_stall),
                                       32'(rows[i].stall));
            tick();
            chk($sformatf("row%0d_count", i), 32'(m_cnt), 32'(rows[i].cnt));
            chk($sformatf("row%0d_overflow", i), 32'(m_ovf), 32'(rows[i].ovf));
            if (i == 0) begin
                chk("reset_wen", 32'(m_wen), 32'd0);
                chk("reset_addr", m_addr, 32'h0);
                chk("reset_data", m_data, 32'h0);
                chk("reset_full", 32'(m_full), 32'd0);
            end
        end
        chk("main_pending_after_table", q_main.size(), 0);

        // Wrap-around and halt-on-full, same six pushes into both small instances.
        drive(1, 0, 0, 0, 1);
        tick();
        chk("wrap_reset_addr", w_addr, 32'h100);
        mon_main = 1'b0;
        mon_wrap = 1'b1;
        mon_halt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            q_wrap.push_back('{addr: 32'h100 + 32'(4 * (i % 4)), data: 32'hB0000000 + 32'(i)});
            if (i < 4) q_halt.push_back('{addr: 32'(4 * i), data: 32'hB0000000 + 32'(i)});
            drive(0, 0, 1, 32'hB0000000 + 32'(i), 1);
            tick();
        end
        drive(0, 0, 0, 0, 1);
        repeat (3) tick();
        chk("wrap_count", 32'(w_cnt), 32'd6);
        chk("wrap_full", 32'(w_full), 32'd0);
        chk("wrap_pending", q_wrap.size(), 0);
        chk("halt_count", 32'(h_cnt), 32'd4);
        chk("halt_full", 32'(h_full), 32'd1);
        chk("halt_stall_partial", 32'(h_stall), 32'd0);
        chk("halt_pending", q_halt.size(), 0);

        mon_wrap = 1'b0;
        drive(0, 0, 1, 32'hB0000006, 1);
        tick();
        drive(0, 0, 1, 32'hB0000007, 1);
        tick();
        drive(0, 0, 1, 32'hB0000008, 1);
        #1;
        chk("halt_stall_full", 32'(h_stall), 32'd1);
        tick();
        chk("halt_overflow", 32'(h_ovf), 32'd1);
        chk("halt_count_held", 32'(h_cnt), 32'd4);
        drive(0, 1, 0, 0, 1);
        tick();
        chk("restart_wen", 32'(h_wen), 32'd0);
        chk("restart_full", 32'(h_full), 32'd0);
        chk("restart_count", 32'(h_cnt), 32'd0);
        chk("restart_overflow", 32'(h_ovf), 32'd0);
        drive(0, 0, 0, 0, 1);
        #1;
        chk("restart_stall", 32'(h_stall), 32'd0);
        repeat (3) tick();
        // Buffered words were discarded: the next write is the new word at word 0.
        q_halt.push_back('{addr: 32'h0, data: 32'hC0FFEE00});
        drive(0, 0, 1, 32'hC0FFEE00, 1);
        tick();
        drive(0, 0, 0, 0, 1);
        repeat (3) tick();
        chk("restart_new_pending", q_halt.size(), 0);
        chk("restart_new_count", 32'(h_cnt), 32'd1);
        mon_halt = 1'b0;

        // Full FIFO with simultaneous push and pop: no stall, no bubbles.
        drive(1, 0, 0, 0, 1);
        tick();
        mon_main = 1'b1;
        for (int i = 0; i < 14; i++) begin
            q_main.push_back('{addr: 32'(4 * i), data: 32'hD0000000 + 32'(i)});
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 32'hD0000000 + 32'(i), 0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 32'hD0000004 + 32'(i), 1);
            #1;
            chk($sformatf("stream%0d_stall", i), 32'(m_stall), 32'd0);
            tick();
            chk($sformatf("stream%0d_count", i), 32'(m_cnt), 32'(i + 1));
        end
        drive(0, 0, 0, 0, 1);
        repeat (5) tick();
        chk("stream_count", 32'(m_cnt), 32'd14);
        chk("stream_overflow", 32'(m_ovf), 32'd0);
        chk("stream_pending", q_main.size(), 0);

        // Reset while three words are buffered: they must never be written.
        drive(1, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'hE0000000 + 32'(i), 0);
            tick();
        end
        drive(1, 0, 0, 0, 1);
        tick();
        chk("midrst_wen", 32'(m_wen), 32'd0);
        chk("midrst_count", 32'(m_cnt), 32'd0);
        chk("midrst_overflow", 32'(m_ovf), 32'd0);
        drive(0, 0, 0, 0, 1);
        repeat (4) tick();
        chk("midrst_count_after", 32'(m_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
